// File: rtl/seq_mem_bist.sv
// Memory BIST sequencer: seeded pattern fill, per-word single-bit flip, read-back compare.
// Optional macro SEQ_MEM_BIST_INJECT_EN adds an inject input that suppresses the last flip.
module seq_mem_bist #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    localparam int BIT_W = $clog2(DATA_W),
    localparam int DEPTH = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
`ifdef SEQ_MEM_BIST_INJECT_EN
    input  logic              inject,
`endif
    input  logic [DATA_W-1:0] seed,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              mask_en,
    output logic [ADDR_W-1:0] mask_addr,
    output logic [BIT_W-1:0]  bit_index,
    output logic              bit_value,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_fail
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_FLIP  = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    function automatic logic [DATA_W-1:0] pattern(input logic [DATA_W-1:0] s,
                                                  input logic [ADDR_W-1:0] a);
        return s ^ DATA_W'(a);
    endfunction

    function automatic logic [DATA_W-1:0] expected(input logic [DATA_W-1:0] s,
                                                   input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] m;
        m = '0;
        m[a[BIT_W-1:0]] = 1'b1;
        return pattern(s, a) ^ m;
    endfunction

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_seed;
    logic              r_inject;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [ADDR_W-1:0] r_mask_addr;
    logic [BIT_W-1:0]  r_bit_index;
    logic              r_bit_value;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_vld_p1;
    logic [ADDR_W-1:0] r_addr_p1;
    logic [ADDR_W:0]   r_err_count;
    logic [ADDR_W-1:0] r_first_fail;

    logic              w_last;
    logic              w_idle;
    logic              w_launch;
    logic [DATA_W-1:0] w_pat;
    logic [BIT_W-1:0]  w_bidx;
    logic              w_rd_en;
    logic              w_mismatch;

    assign w_last     = (r_cnt == ADDR_W'(DEPTH - 1));
    assign w_idle     = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_launch   = w_idle && start;
    assign w_pat      = pattern(r_seed, r_cnt);
    assign w_bidx     = r_cnt[BIT_W-1:0];
    assign w_rd_en    = (r_state == S_READ);
    assign w_mismatch = r_vld_p1 && (rd_data != expected(r_seed, r_addr_p1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_seed   <= '0;
            r_inject <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_cnt <= '0;
                    if (start) begin
                        r_seed  <= seed;
`ifdef SEQ_MEM_BIST_INJECT_EN
                        r_inject <= inject;
`else
                        r_inject <= 1'b0;
`endif
                        r_state <= S_WRITE;
                    end
                end
                // counter wraps to 0 on the last word, which clears it for the next phase
                S_WRITE: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) r_state <= S_FLIP;
                end
                S_FLIP: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) r_state <= S_READ;
                end
                S_READ: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) r_state <= S_CHECK;
                end
                S_CHECK: begin
                    r_cnt   <= '0;
                    r_state <= S_DONE;
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign wr_en   = (r_state == S_WRITE);
    assign mask_en = (r_state == S_FLIP) && !(r_inject && w_last);

    // Hold registers keep each port's last issued value while its strobe is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_mask_addr <= '0;
            r_bit_index <= '0;
            r_bit_value <= 1'b0;
            r_rd_addr   <= '0;
        end else begin
            if (wr_en) begin
                r_wr_addr <= r_cnt;
                r_wr_data <= w_pat;
            end
            if (mask_en) begin
                r_mask_addr <= r_cnt;
                r_bit_index <= w_bidx;
                r_bit_value <= ~w_pat[w_bidx];
            end
            if (w_rd_en) r_rd_addr <= r_cnt;
        end
    end

    assign wr_addr   = wr_en   ? r_cnt            : r_wr_addr;
    assign wr_data   = wr_en   ? w_pat            : r_wr_data;
    assign mask_addr = mask_en ? r_cnt            : r_mask_addr;
    assign bit_index = mask_en ? w_bidx           : r_bit_index;
    assign bit_value = mask_en ? ~w_pat[w_bidx]   : r_bit_value;
    assign rd_addr   = w_rd_en ? r_cnt            : r_rd_addr;

    // p0 -> p1: read issue aligned with the memory's one-cycle data return
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_vld_p1 <= 1'b0;
        else        r_vld_p1 <= w_rd_en;
    end

    always_ff @(posedge clk) begin
        r_addr_p1 <= r_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count  <= '0;
            r_first_fail <= '0;
        end else if (w_launch) begin
            r_err_count  <= '0;
            r_first_fail <= '0;
        end else if (w_mismatch) begin
            r_err_count <= r_err_count + 1'b1;
            if (r_err_count == '0) r_first_fail <= r_addr_p1;
        end
    end

    assign err_count  = r_err_count;
    assign first_fail = r_first_fail;
    assign done       = (r_state == S_DONE);
    assign busy       = !w_idle;
    assign pass       = done && (r_err_count == '0);

endmodule

// File: tb/tb_seq_mem_bist.sv
// Bench for seq_mem_bist: 16x8 memory model with stuck-at faults and an abstract result model.
module tb_seq_mem_bist;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] seed;
`ifdef SEQ_MEM_BIST_INJECT_EN
    logic       inject;
`endif
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       mask_en;
    logic [3:0] mask_addr;
    logic [2:0] bit_index;
    logic       bit_value;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_count;
    logic [3:0] first_fail;

    seq_mem_bist #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
`ifdef SEQ_MEM_BIST_INJECT_EN
        .inject(inject),
`endif
        .seed(seed), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .mask_en(mask_en), .mask_addr(mask_addr), .bit_index(bit_index),
        .bit_value(bit_value), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_fail(first_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [16];
    logic [7:0] s0  [16];
    logic [7:0] s1  [16];

    // Synchronous memory: word write, bit write, registered read with stuck-at faults on readout.
    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (mask_en) mem[mask_addr][bit_index] <= bit_value;
        rd_data <= (mem[rd_addr] & ~s0[rd_addr]) | s1[rd_addr];
    end

    int n_wr = 0, n_mask = 0, n_both = 0, n_mask15 = 0;
    always @(negedge clk) begin
        if (wr_en) n_wr++;
        if (mask_en) n_mask++;
        if (wr_en && mask_en) n_both++;
        if (mask_en && mask_addr == 4'd15) n_mask15++;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic clear_faults();
        for (int a = 0; a < 16; a++) begin
            s0[a] = 8'h00;
            s1[a] = 8'h00;
        end
    endtask

    int         m_err;
    int         m_ff;
    logic [7:0] exp_img [16];

    // Reference: stored words are the flipped pattern (unless injected); reads compare to the flipped pattern.
    task automatic model(input logic [7:0] sd, input bit inj);
        m_err = 0;
        m_ff  = 0;
        for (int a = 0; a < 16; a++) begin
            logic [7:0] want;
            logic [7:0] got;
            want = (sd ^ 8'(a));
            want[a % 8] = ~want[a % 8];
            exp_img[a] = (inj && a == 15) ? (sd ^ 8'(a)) : want;
            got = (exp_img[a] & ~s0[a]) | s1[a];
            if (got != want) begin
                if (m_err == 0) m_ff = a;
                m_err++;
            end
        end
    endtask

    task automatic run(input logic [7:0] sd, input bit inj, input bit poke, input string tag);
        int lat;
        int w0, k0, b0, q0;
        int nbad;
        model(sd, inj);
        w0 = n_wr; k0 = n_mask; b0 = n_both; q0 = n_mask15;
        @(negedge clk);
        seed  = sd;
`ifdef SEQ_MEM_BIST_INJECT_EN
        inject = inj;
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        chk({tag, "_go"}, {busy, done, err_count}, 64);
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
            start = (poke && lat == 40);
        end
        start = 1'b0;
        chk({tag, "_lat"}, lat, 49);
        chk({tag, "_err"}, err_count, m_err);
        chk({tag, "_ff"}, first_fail, m_ff);
        chk({tag, "_pass"}, pass, (m_err == 0));
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_nwr"}, n_wr - w0, 16);
        chk({tag, "_nmask"}, n_mask - k0, inj ? 15 : 16);
        chk({tag, "_both"}, n_both - b0, 0);
        chk({tag, "_m15"}, n_mask15 - q0, inj ? 0 : 1);
        nbad = 0;
        for (int a = 0; a < 16; a++) if (mem[a] !== exp_img[a]) nbad++;
        chk({tag, "_mem"}, nbad, 0);
    endtask

    typedef struct {
        logic [7:0] seed;
        int         fa0;
        logic [7:0] m0;
        int         fa1;
        logic [7:0] m1;
        int         e_err;
        int         e_ff;
        bit         e_pass;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int lat;
        tbl[0] = '{8'hA5, 0, 8'h00, 0, 8'h00, 0, 0, 1'b1};
        tbl[1] = '{8'hA5, 5, 8'h80, 0, 8'h00, 1, 5, 1'b0};
        tbl[2] = '{8'hA5, 2, 8'h01, 9, 8'h01, 2, 2, 1'b0};
        tbl[3] = '{8'h00, 0, 8'h00, 0, 8'h80, 1, 0, 1'b0};
        tbl[4] = '{8'hA5, 5, 8'h01, 0, 8'h00, 0, 0, 1'b1};

        for (int a = 0; a < 16; a++) mem[a] = 8'h00;
        clear_faults();
        start = 1'b0;
        seed  = 8'h00;
`ifdef SEQ_MEM_BIST_INJECT_EN
        inject = 1'b0;
`endif
        rst_n = 1'b0;
        #1;
        chk("rst_ctl", {wr_en, mask_en, busy, done, pass, bit_value}, 0);
        chk("rst_addr", {wr_addr, mask_addr, rd_addr, first_fail, bit_index}, 0);
        chk("rst_data", {wr_data, err_count}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            clear_faults();
            s0[tbl[i].fa0] = tbl[i].m0;
            s1[tbl[i].fa1] = tbl[i].m1;
            run(tbl[i].seed, 1'b0, 1'b0, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_xerr", i), err_count, tbl[i].e_err);
            chk($sformatf("tbl%0d_xff", i), first_fail, tbl[i].e_ff);
            chk($sformatf("tbl%0d_xpass", i), pass, tbl[i].e_pass);
            if (i == 0) begin
                chk("mem3", mem[3], 8'hAE);
                chk("mem0", mem[0], 8'hA4);
            end
        end

        // Faults at 2 and 9, then back-to-back restarts from DONE.
        clear_faults();
        s0[2] = 8'h01;
        s1[9] = 8'h01;
        run(8'hA5, 1'b0, 1'b0, "b2b_a");
        run(8'hA5, 1'b0, 1'b0, "b2b_b");
        chk("b2b_err", err_count, 2);
        chk("b2b_ff", first_fail, 2);

        // start pulsed in READ must be ignored.
        run(8'hA5, 1'b0, 1'b1, "poke");
        chk("poke_err", err_count, 2);

        // Async reset in the middle of FLIP.
        clear_faults();
        @(negedge clk);
        seed  = 8'h5A;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!(mask_en && mask_addr == 4'd7) && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("flip7_reached", lat, 23);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctl", {wr_en, mask_en, busy, done, pass, bit_value}, 0);
        chk("mid_rst_addr", {wr_addr, mask_addr, rd_addr, first_fail, bit_index}, 0);
        chk("mid_rst_data", {wr_data, err_count}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(8'h00, 1'b0, 1'b0, "post_rst");
        chk("post_rst_pass", pass, 1);

        // Random seeds and random stuck-at faults against the reference model.
        for (int r = 0; r < 8; r++) begin
            int nf;
            clear_faults();
            nf = $urandom_range(0, 2);
            for (int f = 0; f < nf; f++) begin
                int         fa;
                logic [7:0] fm;
                fa = $urandom_range(0, 15);
                fm = 8'h01 << $urandom_range(0, 7);
                if ($urandom_range(0, 1) == 1) s0[fa] = s0[fa] | fm;
                else                           s1[fa] = s1[fa] | fm;
            end
            run(8'($urandom), 1'b0, 1'b0, $sformatf("rnd%0d", r));
        end

`ifdef SEQ_MEM_BIST_INJECT_EN
        clear_faults();
        run(8'h3C, 1'b1, 1'b0, "inj");
        chk("inj_err", err_count, 1);
        chk("inj_ff", first_fail, 15);
        chk("inj_pass", pass, 0);
        run(8'h3C, 1'b0, 1'b0, "inj_off");
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/seq_mem_bist.md
Name: seq_mem_bist

Overview:
- Built-in self-test sequencer that drives the write, bit-masked write and registered read ports of a DEPTH x DATA_W synchronous memory.
- Fills the memory with a seeded pattern, then inverts one bit per word through the bit-write port.
- Reads every word back, compares each against the expected value, and reports pass/fail, error count and the first failing address.

Parameters:
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words.
- DATA_W, 8, word width; must be a power of two, 2..2**ADDR_W.
- BIT_W, $clog2(DATA_W), bit-index width (derived, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin test; sampled only in IDLE or DONE.
- seed  in  DATA_W  pattern seed; captured on the start edge.
- wr_en  out  1  full-word write strobe.
- wr_addr  out  ADDR_W  full-word write address.
- wr_data  out  DATA_W  full-word write data.
- mask_en  out  1  single-bit write strobe.
- mask_addr  out  ADDR_W  bit-write word address.
- bit_index  out  BIT_W  bit-write bit position.
- bit_value  out  1  bit-write value.
- rd_addr  out  ADDR_W  read address; memory returns data one cycle later.
- rd_data  in  DATA_W  registered read data from memory.
- busy  out  1  test in progress.
- done  out  1  test complete; holds until the next start.
- pass  out  1  valid when done; 1 if err_count == 0.
- err_count  out  ADDR_W+1  number of mismatching words.
- first_fail  out  ADDR_W  address of the first mismatch; 0 if none.

Behaviour:
- Reset (async, rst_n=0): state IDLE; every output 0, including the address outputs. Reset mid-test aborts immediately to IDLE.
- Pattern: P(a) = seed_q ^ zero_extend(a), truncated to DATA_W.
- Expected value: E(a) = P(a) with bit (a mod DATA_W) inverted.
- States: IDLE, WRITE, FLIP, READ, CHECK, DONE. An internal counter cnt (ADDR_W bits) is cleared on every phase entry.
- IDLE / DONE, start=1: capture seed, clear err_count/first_fail/pass/done, go to WRITE, busy=1.
- WRITE: wr_en=1, wr_addr=cnt, wr_data=P(cnt) for DEPTH cycles. When cnt wraps from DEPTH-1, go to FLIP.
- FLIP: mask_en=1, mask_addr=cnt, bit_index=cnt mod DATA_W, bit_value=~P(cnt)[bit_index] for DEPTH cycles, then go to READ.
- READ: rd_addr=cnt for DEPTH cycles.
- Compare pipeline: a read-valid flag and the address are delayed one cycle. On each delayed-valid cycle, compare rd_data with E(addr_d):
  - on mismatch, increment err_count;
  - if this is the first mismatch, latch first_fail=addr_d.
- CHECK: one cycle; performs the compare for the last read, then goes to DONE.
- DONE: done=1, busy=0, pass=(err_count==0). Results hold until the next start or reset.
- Strobe rules:
  - wr_en and mask_en are never both high.
  - All strobes are 0 outside their phase.
  - Address/data outputs hold their last value when their strobe is low.
- Latency: done rises 3*DEPTH+1 cycles after the start sampling edge (49 for defaults).
- start while busy is ignored. start held high in DONE restarts the test every time DONE is reached.
- err_count cannot overflow: max value DEPTH fits in ADDR_W+1 bits.

Optional Feature:
- Macro: SEQ_MEM_BIST_INJECT_EN.
- Defined:
  - Adds input port inject (1 bit), captured together with seed on the start edge.
  - If captured high, the FLIP write at address DEPTH-1 is suppressed (mask_en stays 0 that cycle).
  - On healthy memory this yields exactly one mismatch: err_count=1, first_fail=DEPTH-1, pass=0.
- Undefined: no inject port; all DEPTH flips are always issued.

Test Plan:
- Healthy 16x8 memory model, seed=8'hA5, start pulse -> done at cycle 49, pass=1, err_count=0. Bench memory holds mem[3]=8'hAE and mem[0]=8'hA4.
- Bench memory with bit 7 of addr 5 stuck at 0 -> err_count=1, first_fail=5, pass=0; read of addr 5 returns 8'h00 vs expected 8'h80.
- Stuck faults at addr 2 and addr 9 -> err_count=2, first_fail=2. A back-to-back restart from DONE clears the results, then reports the same values.
- rst_n pulsed low during FLIP (cnt=7) -> all outputs 0 asynchronously. A subsequent start with seed=8'h00 runs to completion with pass=1.
- start asserted during READ -> ignored: done timing unchanged and results unchanged.
- SEQ_MEM_BIST_INJECT_EN defined, inject=1, seed=8'h3C, healthy memory -> no mask_en at addr 15, err_count=1, first_fail=15, pass=0.
